// File: rtl/shift_pkg.sv
`timescale 1ns/1ps
// Shared select codes, FSM state encoding and the direction-to-select helper
// used by the shift sequencer and its bench.
package shift_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        PAR   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // dir=1 sends the MSB out first, which means a left shift.
    function automatic logic [1:0] sel_for_dir(input logic dir);
        return dir ? SEL_LEFT : SEL_RIGHT;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
`timescale 1ns/1ps
// Counts shift beats of one word; tc flags the last beat (WIDTH-1).
// Latency: count updates on the edge after en; tc is combinational from count.
// Backpressure: none; saturates at WIDTH-1 instead of wrapping.
module shift_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
`timescale 1ns/1ps
// Drives a universal shift register as a parallel-to-serial transmitter (SHIFT_SEQ_PARITY_EN adds a parity beat).
// Latency: accept -> LOAD next cycle -> WIDTH serial beats -> done pulse; word period WIDTH+3 (+1 with parity).
// Backpressure: in_ready only in IDLE; inputs are latched at accept and never re-sampled mid-word.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_fill,
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_i,
    output logic             sr_r,
    input  logic [WIDTH-1:0] sr_q,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic             fill_q;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    assign accept = in_valid && (state == IDLE);

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else if (accept) begin
            data_q <= in_data;
            dir_q  <= in_dir;
            fill_q <= in_fill;
        end
    end

    always_comb begin
        state_n = state;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_n = LOAD;
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
`ifdef SHIFT_SEQ_PARITY_EN
                    state_n = PAR;
`else
                    state_n = DONE;
`endif
                end
            end
            PAR: begin
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Moore decode; ser_out in SHIFT is the only path from an input (sr_q).
    always_comb begin
        in_ready  = 1'b0;
        sr_s      = SEL_HOLD;
        sr_i      = '0;
        sr_r      = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD: begin
                sr_s = SEL_LOAD;
                sr_i = data_q;
            end
            SHIFT: begin
                sr_s      = sel_for_dir(dir_q);
                sr_r      = fill_q;
                ser_valid = 1'b1;
                ser_out   = dir_q ? sr_q[WIDTH-1] : sr_q[0];
            end
`ifdef SHIFT_SEQ_PARITY_EN
            PAR: begin
                ser_valid = 1'b1;
                ser_out   = ^data_q;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
`timescale 1ns/1ps
// Bench for shift_sequencer: behavioural 8-bit universal shift register in the
// loop, table-driven words plus reset, back-to-back and mid-word-reset sequences.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_PARITY_EN
    localparam int NB       = 9;
    localparam int EXP_DONE = 11;
`else
    localparam int NB       = 8;
    localparam int EXP_DONE = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic       in_fill;
    logic [1:0] sr_s;
    logic [7:0] sr_i;
    logic       sr_r;
    logic [7:0] sr_q;
    logic       ser_out;
    logic       ser_valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_fill   (in_fill),
        .sr_s      (sr_s),
        .sr_i      (sr_i),
        .sr_r      (sr_r),
        .sr_q      (sr_q),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural universal shift register, cleared by the same reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= 8'h00;
        end else begin
            case (sr_s)
                2'b01:   sr_q <= {sr_r, sr_q[7:1]};
                2'b10:   sr_q <= {sr_q[6:0], sr_r};
                2'b11:   sr_q <= sr_i;
                default: sr_q <= sr_q;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE, #1 after an edge. Returns at the done cycle (or after a bound).
    task automatic run_word(input logic [7:0] d, input logic dr, input logic fl,
                            output logic [1:0] lsel, output int nbeats,
                            output logic [8:0] bits, output int dcyc, output int ndone);
        in_data  = d;
        in_dir   = dr;
        in_fill  = fl;
        in_valid = 1'b1;
        step();
        // Scramble inputs after acceptance: the word must be unaffected.
        in_valid = 1'b0;
        in_data  = ~d;
        in_dir   = ~dr;
        in_fill  = ~fl;
        lsel   = sr_s;
        nbeats = 0;
        bits   = '0;
        dcyc   = -1;
        ndone  = 0;
        for (int c = 1; c <= 30 && dcyc < 0; c++) begin
            if (ser_valid) begin
                if (nbeats < 9) bits[nbeats] = ser_out;
                nbeats++;
            end
            if (done) begin
                dcyc = c;
                ndone++;
            end
            if (dcyc < 0) step();
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic       fill;
        logic [7:0] exp_ser;  // bit i = i-th beat
        logic       exp_par;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[4];

    logic [1:0]  lsel;
    int          nbeats;
    logic [8:0]  bits;
    int          dcyc;
    int          ndone;
    logic [17:0] stream;
    int          sidx;
    int          accepts;
    int          acc_cyc[2];
    int          dcount;

    initial begin
        vecs[0] = '{data: 8'hA5, dir: 1'b0, fill: 1'b0, exp_ser: 8'hA5, exp_par: 1'b0, exp_q: 8'h00};
        vecs[1] = '{data: 8'h3C, dir: 1'b1, fill: 1'b1, exp_ser: 8'h3C, exp_par: 1'b0, exp_q: 8'hFF};
        vecs[2] = '{data: 8'hC1, dir: 1'b1, fill: 1'b0, exp_ser: 8'h83, exp_par: 1'b1, exp_q: 8'h00};
        vecs[3] = '{data: 8'h5A, dir: 1'b0, fill: 1'b1, exp_ser: 8'h5A, exp_par: 1'b0, exp_q: 8'hFF};

        // Reset held with in_valid high: IDLE outputs, nothing accepted.
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_dir   = 1'b0;
        in_fill  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_sr_s", int'(sr_s), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
        end
        chk("rst_ser_valid", int'(ser_valid), 0);
        chk("rst_sr_i", int'(sr_i), 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        chk("post_rst_busy", int'(busy), 0);

        // Table-driven words.
        for (int v = 0; v < 4; v++) begin
            run_word(vecs[v].data, vecs[v].dir, vecs[v].fill, lsel, nbeats, bits, dcyc, ndone);
            chk($sformatf("v%0d_load_sel", v), int'(lsel), 3);
            chk($sformatf("v%0d_beats", v), nbeats, NB);
            chk($sformatf("v%0d_ser", v), int'(bits[7:0]), int'(vecs[v].exp_ser));
`ifdef SHIFT_SEQ_PARITY_EN
            chk($sformatf("v%0d_par", v), int'(bits[8]), int'(vecs[v].exp_par));
`endif
            chk($sformatf("v%0d_done_cyc", v), dcyc, EXP_DONE);
            chk($sformatf("v%0d_final_q", v), int'(sr_q), int'(vecs[v].exp_q));
            chk($sformatf("v%0d_ready_in_done", v), int'(in_ready), 0);
            step();
            chk($sformatf("v%0d_idle_busy", v), int'(busy), 0);
            chk($sformatf("v%0d_idle_done", v), int'(done), 0);
            chk($sformatf("v%0d_held_q", v), int'(sr_q), int'(vecs[v].exp_q));
        end

        // Back-to-back with in_valid held high: 8'h01 then 8'h80.
        in_data  = 8'h01;
        in_dir   = 1'b0;
        in_fill  = 1'b0;
        in_valid = 1'b1;
        accepts  = 0;
        dcount   = 0;
        sidx     = 0;
        stream   = '0;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        for (int c = 0; c < 32; c++) begin
            logic took;
            took = in_valid && in_ready;
            if (took) begin
                if (accepts < 2) acc_cyc[accepts] = c;
                accepts++;
            end
            if (ser_valid) begin
                if (sidx < 18) stream[sidx] = ser_out;
                sidx++;
            end
            if (done) dcount++;
            step();
            if (took && accepts == 1) in_data = 8'h80;
            if (took && accepts == 2) in_valid = 1'b0;
        end
        chk("b2b_accepts", accepts, 2);
        chk("b2b_gap", acc_cyc[1] - acc_cyc[0], NB + 3);
        chk("b2b_beats", sidx, 2 * NB);
        chk("b2b_word1", int'(stream[7:0]), 8'h01);
        chk("b2b_word2", int'(stream[NB +: 8]), 8'h80);
        chk("b2b_dones", dcount, 2);

        // Reset during the 4th shift of 8'hFF.
        in_data  = 8'hFF;
        in_dir   = 1'b0;
        in_fill  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_in_shift", int'(sr_s), 1);
        reset = 1'b0;
        #1;
        chk("mid_async_busy", int'(busy), 0);
        chk("mid_async_sr_s", int'(sr_s), 0);
        chk("mid_async_ser_valid", int'(ser_valid), 0);
        step();
        reset = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dcount++;
            step();
        end
        chk("mid_no_done", dcount, 0);

        run_word(8'h0F, 1'b0, 1'b0, lsel, nbeats, bits, dcyc, ndone);
        chk("after_load_sel", int'(lsel), 3);
        chk("after_beats", nbeats, NB);
        chk("after_ser", int'(bits[7:0]), 8'h0F);
`ifdef SHIFT_SEQ_PARITY_EN
        chk("after_par", int'(bits[8]), 0);
`endif
        chk("after_done_cyc", dcyc, EXP_DONE);
        chk("after_final_q", int'(sr_q), 8'h00);

`ifdef SHIFT_SEQ_PARITY_EN
        step();
        run_word(8'h07, 1'b0, 1'b0, lsel, nbeats, bits, dcyc, ndone);
        chk("par07_beats", nbeats, 9);
        chk("par07_last", int'(bits[8]), 1);
        chk("par07_done_cyc", dcyc, 11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
